// File: rtl/fp_mul_driver.sv
// Start/done initiator for the multiplier32FP: buffers operand pairs, issues one at a time,
// and returns product, flags and sequence tag on a result stream, with a hang watchdog.
module fp_mul_driver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  output logic [31:0]      mul_a_o,
  output logic [31:0]      mul_b_o,
  output logic             mul_start_o,
  input  logic             mul_done_i,
  input  logic [31:0]      mul_product_i,
  input  logic [3:0]       mul_flags_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_product_o,
  output logic [4:0]       res_flags_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  // Both streams use the same handshake: a beat transfers on the rising edge where
  // valid and ready are both high; valid never depends on ready, and the payload holds
  // steady while valid is high and ready is low.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       mem_a [FIFO_DEPTH];
  logic [31:0]       mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WD_W-1:0]   wd;
  logic [TAG_W-1:0]  tag_cnt;
  logic [TAG_W-1:0]  cur_tag;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              res_free;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign op_ready_o = !rst && !full;
  assign push       = op_valid_i && op_ready_o;
  assign res_free   = !res_valid_o || res_ready_i;
  assign pop        = (state == S_IDLE) && !empty && res_free;
  assign busy_o     = (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a_i;
      mem_b[wr_ptr] <= op_b_i;
    end
  end

  // Occupancy only moves when exactly one of push/pop fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mul_a_o       <= '0;
      mul_b_o       <= '0;
      mul_start_o   <= 1'b0;
      wd            <= '0;
      tag_cnt       <= '0;
      cur_tag       <= '0;
      res_valid_o   <= 1'b0;
      res_product_o <= '0;
      res_flags_o   <= '0;
      res_tag_o     <= '0;
    end else begin
      mul_start_o <= 1'b0;
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            mul_a_o     <= mem_a[rd_ptr];
            mul_b_o     <= mem_b[rd_ptr];
            cur_tag     <= tag_cnt;
            tag_cnt     <= tag_cnt + TAG_W'(1);
            mul_start_o <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done_i) begin
            res_product_o <= mul_product_i;
            res_flags_o   <= {1'b0, mul_flags_i};
            res_tag_o     <= cur_tag;
            res_valid_o   <= 1'b1;
            state         <= S_IDLE;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // A hung multiplier yields a quiet NaN flagged as timeout.
            res_product_o <= 32'h7FC0_0000;
            res_flags_o   <= 5'b10000;
            res_tag_o     <= cur_tag;
            res_valid_o   <= 1'b1;
            wd            <= wd + WD_W'(1);
            state         <= S_IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_driver.sv
// Directed bench for fp_mul_driver: a behavioural multiplier, a result scoreboard, and a
// second small-tag instance for tag wraparound.
module tb_fp_mul_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready_o;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] mul_a_o;
  logic [31:0] mul_b_o;
  logic        mul_start_o;
  logic        mul_done_i = 1'b0;
  logic [31:0] mul_product_i = '0;
  logic [3:0]  mul_flags_i = '0;
  logic        res_valid_o;
  logic        res_ready = 1'b0;
  logic [31:0] res_product_o;
  logic [4:0]  res_flags_o;
  logic [15:0] res_tag_o;
  logic        busy_o;

  logic        op_valid2 = 1'b0;
  logic        op_ready2;
  logic [31:0] op_a2 = '0;
  logic [31:0] op_b2 = '0;
  logic [31:0] mul_a2;
  logic [31:0] mul_b2;
  logic        start2;
  logic        done2 = 1'b0;
  logic        s2_prev = 1'b0;
  logic        res_valid2;
  logic        res_ready2 = 1'b1;
  logic [31:0] res_product2;
  logic [4:0]  res_flags2;
  logic [1:0]  res_tag2;
  logic        busy2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [52:0] exp_q[$];

  int          m_lat = 3;
  bit          m_hang = 1'b0;
  int          m_cnt = 0;
  int          m_starts = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_p = '0;
  logic [3:0]  m_f = '0;

  int n2 = 0;
  int wrap_exp[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  fp_mul_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64), .TAG_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready_o), .op_a_i(op_a), .op_b_i(op_b),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_start_o(mul_start_o),
    .mul_done_i(mul_done_i), .mul_product_i(mul_product_i), .mul_flags_i(mul_flags_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_product_o(res_product_o),
    .res_flags_o(res_flags_o), .res_tag_o(res_tag_o), .busy_o(busy_o)
  );

  fp_mul_driver #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(8), .TAG_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid2), .op_ready_o(op_ready2), .op_a_i(op_a2), .op_b_i(op_b2),
    .mul_a_o(mul_a2), .mul_b_o(mul_b2), .mul_start_o(start2),
    .mul_done_i(done2), .mul_product_i(32'h0), .mul_flags_i(4'h0),
    .res_valid_o(res_valid2), .res_ready_i(res_ready2), .res_product_o(res_product2),
    .res_flags_o(res_flags2), .res_tag_o(res_tag2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Behavioural multiplier: done rises m_lat cycles after the start pulse.
  always @(negedge clk) begin
    mul_done_i = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_done_i    = 1'b1;
        mul_product_i = m_p;
        mul_flags_i   = m_f;
        if (busy_o) check("op_hold", {mul_a_o, mul_b_o}, {m_a, m_b});
      end
    end
    if (mul_start_o) begin
      m_starts++;
      m_a = mul_a_o;
      m_b = mul_b_o;
      if (m_a == 32'h4000_0000 && m_b == 32'h4040_0000) begin
        m_p = 32'h40C0_0000; m_f = 4'b0000;
      end else if (m_a == 32'h7F00_0000 && m_b == 32'h4000_0000) begin
        m_p = 32'h7F80_0000; m_f = 4'b0100;
      end else begin
        m_p = m_a ^ m_b; m_f = 4'b0000;
      end
      if (!m_hang) m_cnt = m_lat;
    end
  end

  always @(negedge clk) begin
    done2   = s2_prev;
    s2_prev = start2;
  end

  // Scoreboard: every accepted result must match the head of exp_q.
  always @(negedge clk) begin
    #2;
    if (!rst && res_valid_o && res_ready) begin
      if (exp_q.size() == 0) check("res_unexpected", exp_q.size(), 1);
      else check("res", {res_product_o, res_flags_o, res_tag_o}, exp_q.pop_front());
    end
    if (!rst && res_valid2) begin
      if (n2 < 5) check("tag_wrap", res_tag2, wrap_exp[n2]);
      else check("tag_extra", n2, 4);
      n2++;
    end
  end

  task automatic push(input bit sel, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    if (sel) begin
      op_valid2 = 1'b1; op_a2 = a; op_b2 = b;
      while (!op_ready2 && n < 300) begin step(); n++; end
      check("push2_ready", op_ready2, 1);
      step();
      op_valid2 = 1'b0;
    end else begin
      op_valid = 1'b1; op_a = a; op_b = b;
      while (!op_ready_o && n < 300) begin step(); n++; end
      check("push_ready", op_ready_o, 1);
      step();
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mul_start_o && n < 30) begin step(); n++; end
    check("start_seen", mul_start_o, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int base;
    int n;
    int seen;
    logic [31:0] a;
    logic [31:0] b;

    step();
    step();
    check("rst_op_ready", op_ready_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_start", mul_start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_tag", res_tag_o, 0);
    check("rst_mul_a", mul_a_o, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", op_ready_o, 1);

    // Single operation: 2.0 * 3.0 = 6.0
    m_lat = 3;
    push(0, 32'h4000_0000, 32'h4040_0000);
    wait_start();
    check("t1_mul_a", mul_a_o, 32'h4000_0000);
    check("t1_mul_b", mul_b_o, 32'h4040_0000);
    check("t1_busy_issue", busy_o, 1);
    step();
    check("t1_start_pulse", mul_start_o, 0);
    check("t1_busy_wait", busy_o, 1);
    n = 0;
    while (!mul_done_i && n < 20) begin step(); n++; end
    check("t1_done_seen", mul_done_i, 1);
    check("t1_valid_at_done", res_valid_o, 0);
    step();
    check("t1_valid", res_valid_o, 1);
    check("t1_product", res_product_o, 32'h40C0_0000);
    check("t1_flags", res_flags_o, 5'b00000);
    check("t1_tag", res_tag_o, 0);
    check("t1_idle", busy_o, 0);
    check("t1_a_retained", mul_a_o, 32'h4000_0000);
    exp_q.push_back({32'h40C0_0000, 5'b00000, 16'd0});
    res_ready = 1'b1;
    drain(20);

    // Burst with a stalled result stream
    do_reset();
    res_ready = 1'b0;
    base = m_starts;
    for (int i = 0; i < 6; i++) begin
      a = 32'h3F80_0000 + 32'(i);
      b = 32'h4000_0000 + 32'(i << 4);
      exp_q.push_back({a ^ b, 5'b00000, 16'(i)});
    end
    for (int i = 0; i < 5; i++) push(0, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i << 4));
    check("burst_full", op_ready_o, 0);
    repeat (10) step();
    check("burst_one_start", m_starts - base, 1);
    check("burst_valid_held", res_valid_o, 1);
    check("burst_tag0_held", res_tag_o, 0);
    check("burst_still_full", op_ready_o, 0);
    res_ready = 1'b1;
    push(0, 32'h3F80_0000 + 32'd5, 32'h4000_0000 + 32'd80);
    drain(300);
    check("burst_starts", m_starts - base, 6);

    // Exception flags pass through
    do_reset();
    exp_q.push_back({32'h7F80_0000, 5'b00100, 16'd0});
    push(0, 32'h7F00_0000, 32'h4000_0000);
    drain(40);

    // Watchdog timeout, then normal recovery
    do_reset();
    m_hang = 1'b1;
    exp_q.push_back({32'h7FC0_0000, 5'b10000, 16'd0});
    push(0, 32'h1234_5678, 32'h0F0F_0F0F);
    wait_start();
    n = 0;
    while (!res_valid_o && n < 100) begin step(); n++; end
    check("timeout_latency", n, 65);
    check("timeout_product", res_product_o, 32'h7FC0_0000);
    check("timeout_flags", res_flags_o, 5'b10000);
    drain(10);
    m_hang = 1'b0;
    exp_q.push_back({32'h1111_0000 ^ 32'h0000_2222, 5'b00000, 16'd1});
    push(0, 32'h1111_0000, 32'h0000_2222);
    drain(40);

    // Reset during WAIT, with a second pair queued and a late done
    do_reset();
    m_lat = 5;
    base = m_starts;
    push(0, 32'hAAAA_0000, 32'h0000_5555);
    push(0, 32'hBBBB_0000, 32'h0000_6666);
    wait_start();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (res_valid_o) seen++;
    end
    check("rst_no_result", seen, 0);
    check("rst_idle", busy_o, 0);
    check("rst_fifo_empty", op_ready_o, 1);
    check("rst_no_reissue", m_starts - base, 1);
    m_lat = 3;
    exp_q.push_back({32'hCCCC_0000 ^ 32'h0000_7777, 5'b00000, 16'd0});
    push(0, 32'hCCCC_0000, 32'h0000_7777);
    drain(40);

    // Tag wraparound on the 2-bit tag instance
    for (int i = 0; i < 5; i++) push(1, 32'h0000_0100 + 32'(i), 32'h0000_0200);
    n = 0;
    while (n2 < 5 && n < 200) begin step(); n++; end
    check("wrap_count", n2, 5);

    repeat (3) step();
    check("exp_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
